// File: rtl/sfm_pkg.sv
// Shared types for the softmax job sequencer: the queued job record and the
// sequencer state encoding.
package sfm_pkg;

    // Widest address / length supported by the queued job record.
    localparam int unsigned SFM_ADDR_W = 32;
    localparam int unsigned SFM_LEN_W  = 16;

    typedef struct packed {
        logic [SFM_ADDR_W-1:0] in_addr;
        logic [SFM_ADDR_W-1:0] out_addr;
        logic [SFM_LEN_W-1:0]  row_len;
        logic [SFM_LEN_W-1:0]  n_rows;
        logic [SFM_ADDR_W-1:0] row_stride;
    } sfm_job_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_START = 2'd1,
        SCHED_RUN   = 2'd2,
        SCHED_DONE  = 2'd3
    } sfm_sched_state_t;

endpackage

// File: rtl/sfm_job_queue.sv
// Small FIFO of softmax jobs with occupancy count and synchronous flush.
// Push into a full queue and pop from an empty queue are silently dropped.
module sfm_job_queue
    import sfm_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  sfm_job_t                   data_i,
    input  logic                       pop_i,
    output sfm_job_t                   data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sfm_job_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_s;
    logic             pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign push_s  = push_i && (count_q < CNT_W'(DEPTH));
    assign pop_s   = pop_i && (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; flush discards every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sfm_job_sched.sv
// Softmax job sequencer: queues jobs and walks each one row by row, handing
// per-row addresses/lengths to the controller and pulsing evt_o per job.
module sfm_job_sched
    import sfm_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned ELEM_PER_BEAT = 8,
    parameter int unsigned DEPTH         = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [ADDR_W-1:0]          cfg_in_addr_i,
    input  logic [ADDR_W-1:0]          cfg_out_addr_i,
    input  logic [LEN_W-1:0]           cfg_row_len_i,
    input  logic [LEN_W-1:0]           cfg_n_rows_i,
    input  logic [ADDR_W-1:0]          cfg_row_stride_i,
    output logic                       row_start_o,
    output logic [ADDR_W-1:0]          row_in_addr_o,
    output logic [ADDR_W-1:0]          row_out_addr_o,
    output logic [LEN_W-1:0]           row_tot_len_o,
    input  logic                       row_done_i,
    output logic                       busy_o,
    output logic                       evt_o,
    output logic [$clog2(DEPTH+1)-1:0] jobs_pending_o
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned LOG2_EPB = $clog2(ELEM_PER_BEAT);
    localparam int unsigned LEN_P1   = LEN_W + 1;

    sfm_sched_state_t  state_q, state_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  n_rows_q, n_rows_d;
    logic [LEN_W-1:0]  row_idx_q, row_idx_d;
    logic [LEN_W-1:0]  tot_len_q, tot_len_d;
    logic              row_start_q, evt_q, busy_q;

    sfm_job_t          job_in_s;
    sfm_job_t          head_s;
    logic [CNT_W-1:0]  count_s;
    logic              pop_s;
    logic [LEN_W-1:0]  head_len_s;
    logic [LEN_W-1:0]  head_rows_s;
    logic [LEN_P1-1:0] beat_sum_s;

    // Narrow configuration fields are zero-extended into the shared job record.
    always_comb begin
        job_in_s                        = '0;
        job_in_s.in_addr[ADDR_W-1:0]    = cfg_in_addr_i;
        job_in_s.out_addr[ADDR_W-1:0]   = cfg_out_addr_i;
        job_in_s.row_len[LEN_W-1:0]     = cfg_row_len_i;
        job_in_s.n_rows[LEN_W-1:0]      = cfg_n_rows_i;
        job_in_s.row_stride[ADDR_W-1:0] = cfg_row_stride_i;
    end

    sfm_job_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .push_i  (cfg_valid_i && cfg_ready_o && !clear_i),
        .data_i  (job_in_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .count_o (count_s)
    );

    assign head_len_s  = head_s.row_len[LEN_W-1:0];
    assign head_rows_s = head_s.n_rows[LEN_W-1:0];
    assign beat_sum_s  = {1'b0, head_len_s} + LEN_P1'(ELEM_PER_BEAT - 1);

    // Sequencer next state: pop a job, emit one start per row, finish with evt.
    always_comb begin
        state_d    = state_q;
        in_addr_d  = in_addr_q;
        out_addr_d = out_addr_q;
        stride_d   = stride_q;
        n_rows_d   = n_rows_q;
        row_idx_d  = row_idx_q;
        tot_len_d  = tot_len_q;
        pop_s      = 1'b0;
        if (clear_i) begin
            state_d    = SCHED_IDLE;
            in_addr_d  = '0;
            out_addr_d = '0;
            stride_d   = '0;
            n_rows_d   = '0;
            row_idx_d  = '0;
            tot_len_d  = '0;
        end else begin
            case (state_q)
                SCHED_IDLE: begin
                    if (count_s != '0) begin
                        pop_s      = 1'b1;
                        in_addr_d  = head_s.in_addr[ADDR_W-1:0];
                        out_addr_d = head_s.out_addr[ADDR_W-1:0];
                        stride_d   = head_s.row_stride[ADDR_W-1:0];
                        n_rows_d   = head_rows_s;
                        row_idx_d  = '0;
                        tot_len_d  = LEN_W'(beat_sum_s >> LOG2_EPB);
                        if ((head_rows_s == '0) || (head_len_s == '0)) begin
                            state_d = SCHED_DONE;
                        end else begin
                            state_d = SCHED_START;
                        end
                    end else begin
                        state_d = SCHED_IDLE;
                    end
                end
                SCHED_START: begin
                    state_d = SCHED_RUN;
                end
                SCHED_RUN: begin
                    if (row_done_i) begin
                        if (row_idx_q == (n_rows_q - LEN_W'(1))) begin
                            state_d = SCHED_DONE;
                        end else begin
                            row_idx_d  = row_idx_q + LEN_W'(1);
                            in_addr_d  = in_addr_q + stride_q;
                            out_addr_d = out_addr_q + stride_q;
                            state_d    = SCHED_START;
                        end
                    end else begin
                        state_d = SCHED_RUN;
                    end
                end
                SCHED_DONE: begin
                    state_d = SCHED_IDLE;
                end
                default: begin
                    state_d = SCHED_IDLE;
                end
            endcase
        end
    end

    // Working registers plus output flags registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SCHED_IDLE;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            stride_q    <= '0;
            n_rows_q    <= '0;
            row_idx_q   <= '0;
            tot_len_q   <= '0;
            row_start_q <= 1'b0;
            evt_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_addr_q   <= in_addr_d;
            out_addr_q  <= out_addr_d;
            stride_q    <= stride_d;
            n_rows_q    <= n_rows_d;
            row_idx_q   <= row_idx_d;
            tot_len_q   <= tot_len_d;
            row_start_q <= (state_d == SCHED_START);
            evt_q       <= (state_d == SCHED_DONE);
            busy_q      <= (state_d != SCHED_IDLE);
        end
    end

    assign cfg_ready_o    = (count_s < CNT_W'(DEPTH));
    assign jobs_pending_o = count_s;
    assign row_start_o    = row_start_q;
    assign evt_o          = evt_q;
    assign busy_o         = busy_q;
    assign row_in_addr_o  = in_addr_q;
    assign row_out_addr_o = out_addr_q;
    assign row_tot_len_o  = tot_len_q;

endmodule

// File: tb/tb_sfm_job_sched.sv
// Directed bench for sfm_job_sched: a row scoreboard filled at push time and
// drained on every row_start_o / evt_o, plus directed latency checks.
module tb_sfm_job_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_in, cfg_out, cfg_stride;
    logic [15:0] cfg_len, cfg_rows;
    logic        row_start;
    logic [31:0] row_in, row_out;
    logic [15:0] row_tot;
    logic        row_done;
    logic        busy;
    logic        evt;
    logic [1:0]  pending;

    typedef struct {
        logic [31:0] in_a;
        logic [31:0] out_a;
        logic [15:0] tl;
    } row_t;

    row_t        exp_rows[$];
    int          exp_evt = 0;
    int          start_log[$];
    logic [31:0] start_addr_log[$];
    int          evt_log[$];
    int          cyc = 0;
    int          push_cyc = 0;
    int          last_done_cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          auto_on = 1'b0;
    logic [31:0] cur_in;
    bit          cur_valid = 1'b0;

    sfm_job_sched #(
        .ADDR_W        (32),
        .LEN_W         (16),
        .ELEM_PER_BEAT (8),
        .DEPTH         (2)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (clear),
        .cfg_valid_i      (cfg_valid),
        .cfg_ready_o      (cfg_ready),
        .cfg_in_addr_i    (cfg_in),
        .cfg_out_addr_i   (cfg_out),
        .cfg_row_len_i    (cfg_len),
        .cfg_n_rows_i     (cfg_rows),
        .cfg_row_stride_i (cfg_stride),
        .row_start_o      (row_start),
        .row_in_addr_o    (row_in),
        .row_out_addr_o   (row_out),
        .row_tot_len_o    (row_tot),
        .row_done_i       (row_done),
        .busy_o           (busy),
        .evt_o            (evt),
        .jobs_pending_o   (pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves at the negedge following the accepting edge.
    task automatic push_job(input logic [31:0] in_a, input logic [31:0] out_a,
                            input logic [15:0] len, input logic [15:0] rows,
                            input logic [31:0] stride);
        int          w = 0;
        row_t        r;
        logic [31:0] a_in;
        logic [31:0] a_out;
        logic [16:0] sum;
        while (!cfg_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", cfg_ready, 1);
        cfg_in     = in_a;
        cfg_out    = out_a;
        cfg_len    = len;
        cfg_rows   = rows;
        cfg_stride = stride;
        cfg_valid  = 1'b1;
        sum  = {1'b0, len} + 17'd7;
        a_in  = in_a;
        a_out = out_a;
        if (rows != 16'd0 && len != 16'd0) begin
            for (int i = 0; i < int'(rows); i++) begin
                r.in_a  = a_in;
                r.out_a = a_out;
                r.tl    = sum[18-1-2:3];
                exp_rows.push_back(r);
                a_in  = a_in + stride;
                a_out = a_out + stride;
            end
        end
        exp_evt++;
        push_cyc = cyc + 1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_evt(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!evt && n < max);
        chk("evt_seen", evt, 1);
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!row_start && n < max);
        chk("start_seen", row_start, 1);
    endtask

    // Controller model: row_done_i ten cycles after each row start.
    initial begin
        int cd = 0;
        row_done = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_on) begin
                row_done = 1'b0;
                if (row_start) begin
                    cd = 10;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        row_done      = 1'b1;
                        last_done_cyc = cyc + 1;
                    end
                end
            end else begin
                cd = 0;
            end
        end
    end

    // Output monitor: scoreboard pops on starts and events, row stability.
    initial begin
        row_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (row_start) begin
                    start_log.push_back(cyc);
                    start_addr_log.push_back(row_in);
                    chk("start_expected", exp_rows.size() != 0, 1);
                    if (exp_rows.size() != 0) begin
                        e = exp_rows.pop_front();
                        chk("row_in_addr", row_in, e.in_a);
                        chk("row_out_addr", row_out, e.out_a);
                        chk("row_tot_len", row_tot, e.tl);
                    end
                    cur_in    = row_in;
                    cur_valid = 1'b1;
                end else if (busy && cur_valid && !evt) begin
                    chk("row_in_stable", row_in, cur_in);
                end
                if (evt) begin
                    evt_log.push_back(cyc);
                    chk("evt_expected", exp_evt > 0, 1);
                    if (exp_evt > 0) exp_evt--;
                end
                if (!busy) cur_valid = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int sidx;
        int eidx;
        int ecnt;
        bit seen_busy;
        rst_n      = 1'b0;
        clear      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_in     = 32'd0;
        cfg_out    = 32'd0;
        cfg_len    = 16'd0;
        cfg_rows   = 16'd0;
        cfg_stride = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", row_start, 0);
        chk("rst_evt", evt, 0);
        chk("rst_pending", pending, 0);
        chk("rst_in_addr", row_in, 0);
        chk("rst_tot_len", row_tot, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-row job, done ten cycles after each start.
        auto_on = 1'b1;
        sidx = start_log.size();
        push_job(32'h0000_1000, 32'h0000_8000, 16'd1024, 16'd3, 32'h0000_0800);
        wait_start(20);
        chk("t1_start_latency", cyc, push_cyc + 1);
        wait_evt(200);
        chk("t1_evt_latency", cyc, last_done_cyc);
        chk("t1_start_count", start_log.size() - sidx, 3);
        chk("t1_row3_in", start_addr_log[sidx + 2], 32'h0000_2000);
        @(negedge clk);
        chk("t1_idle_after_evt", busy, 0);

        // Length 13 -> 2 beats; done during the start cycle must be ignored.
        auto_on = 1'b0;
        push_job(32'h0000_2000, 32'h0000_3000, 16'd13, 16'd1, 32'h0000_0100);
        wait_start(20);
        row_done = 1'b1;
        @(negedge clk);
        row_done = 1'b0;
        ecnt = evt_log.size();
        repeat (3) @(negedge clk);
        chk("t2_done_in_start_ignored_busy", busy, 1);
        chk("t2_done_in_start_ignored_evt", evt_log.size(), ecnt);
        row_done      = 1'b1;
        last_done_cyc = cyc + 1;
        @(negedge clk);
        row_done = 1'b0;
        chk("t2_evt_after_done", evt, 1);
        chk("t2_evt_cycle", cyc, last_done_cyc);
        auto_on = 1'b1;
        @(negedge clk);

        // Zero-row and zero-length jobs finish without a row start.
        push_job(32'h0000_5000, 32'h0000_6000, 16'd64, 16'd0, 32'h0000_0100);
        wait_evt(10);
        chk("t3_zero_rows_evt_latency", cyc, push_cyc + 1);
        @(negedge clk);
        push_job(32'h0000_5000, 32'h0000_6000, 16'd0, 16'd2, 32'h0000_0100);
        wait_evt(10);
        chk("t3_zero_len_evt_latency", cyc, push_cyc + 1);
        @(negedge clk);

        // Three back-to-back jobs through a two-entry queue.
        sidx = start_log.size();
        eidx = evt_log.size();
        push_job(32'h0001_0000, 32'h0002_0000, 16'd64, 16'd1, 32'h0000_0100);
        push_job(32'h0001_1000, 32'h0002_1000, 16'd64, 16'd1, 32'h0000_0100);
        push_job(32'h0001_2000, 32'h0002_2000, 16'd64, 16'd1, 32'h0000_0100);
        chk("t4_ready_low_when_full", cfg_ready, 0);
        chk("t4_pending_full", pending, 2);
        wait_evt(100);
        chk("t4_ready_low_at_evt", cfg_ready, 0);
        @(negedge clk);
        chk("t4_ready_low_on_pop_cycle", cfg_ready, 0);
        @(negedge clk);
        chk("t4_ready_high_after_pop", cfg_ready, 1);
        chk("t4_pending_after_pop", pending, 1);
        wait_evt(100);
        wait_evt(100);
        chk("t4_evt_count", evt_log.size() - eidx, 3);
        chk("t4_job2_start_after_evt1", start_log[sidx + 1], evt_log[eidx] + 2);
        chk("t4_job3_start_after_evt2", start_log[sidx + 2], evt_log[eidx + 1] + 2);
        @(negedge clk);

        // Address wrap across 2^32.
        push_job(32'hFFFF_FC00, 32'h0001_0000, 16'd16, 16'd2, 32'h0000_0800);
        wait_evt(100);
        chk("t5_wrap_row2_in", start_addr_log[start_addr_log.size() - 1], 32'h0000_0400);
        @(negedge clk);

        // Clear mid-run with one job queued; clear beats a same-cycle push.
        push_job(32'h0000_4000, 32'h0000_c000, 16'd32, 16'd3, 32'h0000_0200);
        wait_start(20);
        push_job(32'h0000_7000, 32'h0000_d000, 16'd32, 16'd1, 32'h0000_0200);
        chk("t6_pending_before_clear", pending, 1);
        @(negedge clk);
        clear     = 1'b1;
        cfg_valid = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        cfg_valid = 1'b0;
        exp_rows.delete();
        exp_evt = 0;
        chk("t6_clear_busy", busy, 0);
        chk("t6_clear_pending", pending, 0);
        chk("t6_clear_ready", cfg_ready, 1);
        chk("t6_clear_in_addr", row_in, 0);
        chk("t6_clear_out_addr", row_out, 0);
        chk("t6_clear_tot_len", row_tot, 0);
        chk("t6_clear_evt", evt, 0);
        ecnt = evt_log.size();
        seen_busy = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("t6_late_done_ignored", seen_busy, 0);
        chk("t6_no_evt_after_clear", evt_log.size(), ecnt);
        push_job(32'h0000_9000, 32'h0000_a000, 16'd40, 16'd2, 32'h0000_0100);
        wait_evt(100);
        repeat (2) @(negedge clk);

        chk("end_rows_drained", exp_rows.size(), 0);
        chk("end_evts_drained", exp_evt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
